spi_slave_gen2: RTL and testbench
=================================

Name: spi_slave_gen2

Overview:
- Parametrised SPI slave receiver/transmitter. Successor to the fixed 12-bit receive-only slave.
- Adds configurable frame width and bit order, full-duplex MISO transmit, mid-frame abort on CS release, and a held-data handshake with overrun detection.
- Sits at the SPI pins on the slave side. `sync_clock` is the SPI clock as delivered to the slave.

Parameters:
- DATA_WIDTH, 12, bits per frame; legal range 2..32.
- LSB_FIRST, 1, 1 = first received/transmitted bit is bit 0; 0 = first bit is bit DATA_WIDTH-1.
- CNT_W, $clog2(DATA_WIDTH+1), bit counter width; derived, not to be overridden.

Ports:
- sync_clock, input, 1: single clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- CS, input, 1: chip select, active low.
- MOSI, input, 1: serial data in, sampled on posedge sync_clock.
- MISO, output, 1: serial data out, registered.
- tx_data, input, DATA_WIDTH: word to transmit; captured at frame start.
- dout, output, DATA_WIDTH: last completed received word.
- done, output, 1: one-cycle pulse on frame completion.
- dout_valid, output, 1: dout holds an unacknowledged word.
- dout_ack, input, 1: consumer acknowledge; clears dout_valid.
- overrun, output, 1: sticky; a frame completed while dout_valid = 1.
- abort, output, 1: one-cycle pulse; CS rose mid-frame.
- parity_err, output, 1: see Optional Feature.

Behaviour:
- Reset (rst = 1 at posedge): state = IDLE; counter = 0; shift registers = 0; dout = 0; MISO = 0; done = 0; dout_valid = 0; overrun = 0; abort = 0; parity_err = 0. Reset takes priority over every other event, including mid-frame; the partial frame is discarded with no done and no abort.
- FRAME_LEN = DATA_WIDTH, or DATA_WIDTH+1 when PARITY_EN is defined.
- States: IDLE, SHIFT.
- IDLE:
  - done = 0, abort = 0.
  - If CS = 0: go to SHIFT; counter = 0; rx shift register = 0; tx shift register = tx_data; MISO = first tx bit per LSB_FIRST.
  - Else stay in IDLE; MISO = 0.
- SHIFT, CS = 0, each cycle:
  - Sample MOSI into the rx shift register.
    - LSB_FIRST = 1: right shift, new bit enters at MSB, so first bit ends at bit 0.
    - LSB_FIRST = 0: left shift, new bit enters at bit 0.
  - Advance the tx shift register; MISO presents the next bit.
  - counter += 1.
- Frame completion (counter reaches FRAME_LEN-1 and the final bit is sampled):
  - Next cycle: dout = assembled word (data bits only); done = 1 for exactly one cycle; dout_valid = 1; state = IDLE.
  - If dout_valid was already 1 and not being acked that same cycle: overrun = 1 (sticky until rst); dout is still overwritten with the new word.
- Latency: CS low sampled at cycle 0 (IDLE). Bits are sampled at cycles 1..FRAME_LEN. done is high in cycle FRAME_LEN+1.
- Back-to-back frames: if CS is still low in the IDLE cycle after done, a new frame starts. There is exactly one dead cycle between frames; the master must insert one idle clock.
- SHIFT, CS = 1 (abort):
  - Next cycle: state = IDLE; abort = 1 for one cycle; done = 0.
  - dout, dout_valid and counter-dependent outputs are unchanged; counter = 0.
- dout_ack:
  - Clears dout_valid next cycle.
  - If dout_ack is high in the same cycle a frame completes, the new completion wins: dout_valid stays 1, no overrun.
  - dout_ack while dout_valid = 0 is ignored.
- MISO after the last bit: 0 until the next frame start.

Optional Feature:
- Macro: SPI_SLAVE_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing bit: the even-parity bit over the data bits.
  - On completion, parity_err = 1 if the XOR of data bits and parity bit is 1, else 0. parity_err holds until the next completion or rst.
  - MISO transmits the even-parity bit of tx_data as its final bit.
- Not defined: frames are exactly DATA_WIDTH bits; parity_err is tied to 0; no parity logic is synthesised.

Test Plan:
- Reset then idle: rst high 2 cycles, CS = 1 for 10 cycles -> dout = 0x000, done/dout_valid/abort/overrun = 0, MISO = 0.
- LSB_FIRST = 1, DATA_WIDTH = 12: CS low, MOSI sends 0xA5C LSB first, tx_data = 0x3F1 -> done one cycle at cycle 13, dout = 0xA5C, dout_valid = 1, MISO sequence = 0x3F1 LSB first.
- LSB_FIRST = 0, DATA_WIDTH = 8: MOSI sends 0x96 MSB first -> dout = 0x96, single done pulse.
- Abort: CS rises after 5 bits -> abort pulse one cycle, no done, dout keeps its previous value, next full frame 0x123 received correctly.
- Overrun/ack: two frames 0x111 then 0x222 with no dout_ack -> overrun = 1, dout = 0x222. Then dout_ack -> dout_valid = 0, overrun stays 1.
- SPI_SLAVE_PARITY_EN, DATA_WIDTH = 12: 0x007 with parity bit 1 -> parity_err = 0. 0x007 with parity bit 0 -> parity_err = 1, done still pulses.

Source files
------------

// File: rtl/spi_slave_gen2.sv
// SPI slave transceiver: configurable width/bit order, full-duplex MISO, abort on CS release,
// held-data handshake with overrun flag. Define SPI_SLAVE_PARITY_EN for a trailing even-parity bit.
module spi_slave_gen2 #(
    parameter int DATA_WIDTH = 12,
    parameter int LSB_FIRST  = 1,
    parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  sync_clock,
    input  logic                  rst,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  done,
    output logic                  dout_valid,
    input  logic                  dout_ack,
    output logic                  overrun,
    output logic                  abort,
    output logic                  parity_err
);

`ifdef SPI_SLAVE_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef SPI_SLAVE_PARITY_EN
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    // Frame as shifted out: the parity bit always sits on the side that leaves last.
    function automatic logic [FRAME_LEN-1:0] tx_frame(input logic [DATA_WIDTH-1:0] w);
`ifdef SPI_SLAVE_PARITY_EN
        if (LSB_FIRST != 0) begin
            return {even_parity(w), w};
        end else begin
            return {w, even_parity(w)};
        end
`else
        return w;
`endif
    endfunction

    function automatic logic first_bit(input logic [FRAME_LEN-1:0] f);
        if (LSB_FIRST != 0) begin
            return f[0];
        end else begin
            return f[FRAME_LEN-1];
        end
    endfunction

    function automatic logic [FRAME_LEN-1:0] tx_advance(input logic [FRAME_LEN-1:0] f);
        if (LSB_FIRST != 0) begin
            return {1'b0, f[FRAME_LEN-1:1]};
        end else begin
            return {f[FRAME_LEN-2:0], 1'b0};
        end
    endfunction

    function automatic logic [FRAME_LEN-1:0] rx_insert(input logic [FRAME_LEN-1:0] f, input logic b);
        if (LSB_FIRST != 0) begin
            return {b, f[FRAME_LEN-1:1]};
        end else begin
            return {f[FRAME_LEN-2:0], b};
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] data_bits(input logic [FRAME_LEN-1:0] f);
`ifdef SPI_SLAVE_PARITY_EN
        if (LSB_FIRST != 0) begin
            return f[DATA_WIDTH-1:0];
        end else begin
            return f[FRAME_LEN-1:1];
        end
`else
        return f;
`endif
    endfunction

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]  rx_q, rx_d, rx_next;
    logic [FRAME_LEN-1:0]  tx_q, tx_d;
    logic                  miso_q, miso_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  abort_q, abort_d;
`ifdef SPI_SLAVE_PARITY_EN
    logic                  perr_q, perr_d;
`endif

    // Next-state and output computation for the IDLE/SHIFT frame engine.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = 1'b0;
        dout_d    = dout_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        overrun_d = overrun_q;
`ifdef SPI_SLAVE_PARITY_EN
        perr_d    = perr_q;
`endif
        rx_next   = rx_insert(rx_q, MOSI);
        if (dout_ack) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                if (!CS) begin
                    state_d = SHIFT;
                    cnt_d   = {CNT_W{1'b0}};
                    rx_d    = {FRAME_LEN{1'b0}};
                    tx_d    = tx_frame(tx_data);
                    miso_d  = first_bit(tx_frame(tx_data));
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (CS) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == LAST_CNT) begin
                    // Completion outranks a same-cycle ack, so the new word stays flagged valid.
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    rx_d    = rx_next;
                    tx_d    = {FRAME_LEN{1'b0}};
                    dout_d  = data_bits(rx_next);
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    if (valid_q && !dout_ack) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
`ifdef SPI_SLAVE_PARITY_EN
                    perr_d  = ^rx_next;
`endif
                end else begin
                    rx_d   = rx_next;
                    tx_d   = tx_advance(tx_q);
                    miso_d = first_bit(tx_advance(tx_q));
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge sync_clock) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            rx_q      <= {FRAME_LEN{1'b0}};
            tx_q      <= {FRAME_LEN{1'b0}};
            miso_q    <= 1'b0;
            dout_q    <= {DATA_WIDTH{1'b0}};
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
`ifdef SPI_SLAVE_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign MISO       = miso_q;
    assign dout       = dout_q;
    assign done       = done_q;
    assign dout_valid = valid_q;
    assign overrun    = overrun_q;
    assign abort      = abort_q;
`ifdef SPI_SLAVE_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Bench for spi_slave_gen2: 12-bit LSB-first and 8-bit MSB-first instances, table-driven frames
// plus hand-written abort, ack/overrun, reset-mid-frame and (when enabled) parity sequences.
module tb_spi_slave_gen2;

`ifdef SPI_SLAVE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs12 = 1'b1, mosi12 = 1'b0, ack12 = 1'b0;
    logic [11:0] tx12 = 12'h000;
    logic        miso12, done12, valid12, ovr12, abort12, perr12;
    logic [11:0] dout12;
    logic        cs8 = 1'b1, mosi8 = 1'b0, ack8 = 1'b0;
    logic [7:0]  tx8 = 8'h00;
    logic        miso8, done8, valid8, ovr8, abort8, perr8;
    logic [7:0]  dout8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_slave_gen2 #(.DATA_WIDTH(12), .LSB_FIRST(1)) dut (
        .sync_clock(clk), .rst(rst), .CS(cs12), .MOSI(mosi12), .MISO(miso12),
        .tx_data(tx12), .dout(dout12), .done(done12), .dout_valid(valid12),
        .dout_ack(ack12), .overrun(ovr12), .abort(abort12), .parity_err(perr12)
    );

    spi_slave_gen2 #(.DATA_WIDTH(8), .LSB_FIRST(0)) dut8 (
        .sync_clock(clk), .rst(rst), .CS(cs8), .MOSI(mosi8), .MISO(miso8),
        .tx_data(tx8), .dout(dout8), .done(done8), .dout_valid(valid8),
        .dout_ack(ack8), .overrun(ovr8), .abort(abort8), .parity_err(perr8)
    );

    typedef struct {
        logic [31:0] rx;
        logic [31:0] tx;
        logic [31:0] exp_dout;
        logic [31:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack12 = 1'b1;
        @(negedge clk);
        ack12 = 1'b0;
    endtask

    // One complete frame: MOSI bits driven at negedges, MISO captured in transmission order.
    task automatic run_frame(input bit use8, input logic [31:0] rx, input logic [31:0] tx,
                             input bit ack_last, input bit par_flip, input string tag,
                             input logic [31:0] exp_dout, input logic [31:0] exp_miso);
        int          dw;
        int          fl;
        logic [31:0] mask;
        logic [31:0] miso_got;
        logic [31:0] exp_full;
        logic        pbit;
        logic        b;
        bit          early;
        dw       = use8 ? 8 : 12;
        fl       = dw + PAR;
        mask     = use8 ? 32'h0000_00FF : 32'h0000_0FFF;
        pbit     = (^(rx & mask)) ^ par_flip;
        miso_got = 32'h0;
        early    = 1'b0;
        exp_full = exp_miso;
        if (PAR == 1) exp_full[dw] = ^(tx & mask);
        @(negedge clk);
        if (use8) begin cs8 = 1'b0; tx8 = tx[7:0]; end
        else begin cs12 = 1'b0; tx12 = tx[11:0]; end
        for (int k = 0; k < fl; k++) begin
            @(negedge clk);
            if (k >= dw) b = pbit;
            else if (use8) b = rx[dw-1-k];
            else b = rx[k];
            miso_got[k] = use8 ? miso8 : miso12;
            early = early | (use8 ? done8 : done12);
            if (use8) mosi8 = b; else mosi12 = b;
            if (!use8 && k == fl - 1) ack12 = ack_last;
        end
        @(negedge clk);
        ack12 = 1'b0;
        if (use8) cs8 = 1'b1; else cs12 = 1'b1;
        chk({tag, ".done_early"}, 32'(early), 32'h0);
        chk({tag, ".done"}, 32'(use8 ? done8 : done12), 32'h1);
        chk({tag, ".dout"}, use8 ? 32'(dout8) : 32'(dout12), exp_dout);
        chk({tag, ".valid"}, 32'(use8 ? valid8 : valid12), 32'h1);
        chk({tag, ".miso"}, miso_got, exp_full);
        chk({tag, ".perr"}, 32'(use8 ? perr8 : perr12), 32'(PAR == 1 ? par_flip : 1'b0));
        chk({tag, ".miso_after"}, 32'(use8 ? miso8 : miso12), 32'h0);
        @(negedge clk);
        chk({tag, ".done_once"}, 32'(use8 ? done8 : done12), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rx: 32'hA5C, tx: 32'h3F1, exp_dout: 32'hA5C, exp_miso: 32'h3F1};
        vecs[1] = '{rx: 32'h000, tx: 32'hFFF, exp_dout: 32'h000, exp_miso: 32'hFFF};
        vecs[2] = '{rx: 32'hFFF, tx: 32'h000, exp_dout: 32'hFFF, exp_miso: 32'h000};
        vecs[3] = '{rx: 32'h801, tx: 32'h555, exp_dout: 32'h801, exp_miso: 32'h555};

        // Reset, then idle with CS high.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst.dout", 32'(dout12), 32'h0);
        chk("rst.done", 32'(done12), 32'h0);
        chk("rst.valid", 32'(valid12), 32'h0);
        chk("rst.abort", 32'(abort12), 32'h0);
        chk("rst.overrun", 32'(ovr12), 32'h0);
        chk("rst.miso", 32'(miso12), 32'h0);
        chk("rst.perr", 32'(perr12), 32'h0);
        chk("rst.dout8", 32'(dout8), 32'h0);

        foreach (vecs[i]) begin
            run_frame(1'b0, vecs[i].rx, vecs[i].tx, 1'b0, 1'b0, $sformatf("vec%0d", i),
                      vecs[i].exp_dout, vecs[i].exp_miso);
            chk($sformatf("vec%0d.overrun", i), 32'(ovr12), 32'h0);
            pulse_ack();
            chk($sformatf("vec%0d.ack", i), 32'(valid12), 32'h0);
        end

        // MSB-first 8-bit instance.
        run_frame(1'b1, 32'h96, 32'hA3, 1'b0, 1'b0, "msb96", 32'h96, 32'hC5);
        run_frame(1'b1, 32'h01, 32'h80, 1'b0, 1'b0, "msb01", 32'h01, 32'h01);

        // Abort after 5 bits: pulse, no done, previous word kept.
        @(negedge clk);
        cs12 = 1'b0; tx12 = 12'hFFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            mosi12 = k[0];
        end
        @(negedge clk);
        cs12 = 1'b1;
        @(negedge clk);
        chk("abort.pulse", 32'(abort12), 32'h1);
        chk("abort.done", 32'(done12), 32'h0);
        chk("abort.dout", 32'(dout12), 32'h801);
        chk("abort.valid", 32'(valid12), 32'h0);
        @(negedge clk);
        chk("abort.once", 32'(abort12), 32'h0);
        chk("abort.miso", 32'(miso12), 32'h0);
        run_frame(1'b0, 32'h123, 32'h0F0, 1'b0, 1'b0, "post_abort", 32'h123, 32'h0F0);

        // Ack coinciding with completion: new word stays valid, no overrun.
        run_frame(1'b0, 32'h456, 32'h00F, 1'b1, 1'b0, "ack_same", 32'h456, 32'h00F);
        chk("ack_same.overrun", 32'(ovr12), 32'h0);
        pulse_ack();
        chk("ack_same.cleared", 32'(valid12), 32'h0);

        // Overrun: two frames without ack.
        run_frame(1'b0, 32'h111, 32'h000, 1'b0, 1'b0, "ovr1", 32'h111, 32'h000);
        chk("ovr1.overrun", 32'(ovr12), 32'h0);
        run_frame(1'b0, 32'h222, 32'h000, 1'b0, 1'b0, "ovr2", 32'h222, 32'h000);
        chk("ovr2.overrun", 32'(ovr12), 32'h1);
        pulse_ack();
        chk("ovr.ack_valid", 32'(valid12), 32'h0);
        chk("ovr.sticky", 32'(ovr12), 32'h1);
        pulse_ack();
        chk("ovr.ack_idle", 32'(valid12), 32'h0);

        // Reset mid-frame: partial frame discarded without done or abort.
        @(negedge clk);
        cs12 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mosi12 = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1; cs12 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.dout", 32'(dout12), 32'h0);
        chk("rstmid.overrun", 32'(ovr12), 32'h0);
        chk("rstmid.done", 32'(done12), 32'h0);
        chk("rstmid.abort", 32'(abort12), 32'h0);
        @(negedge clk);
        chk("rstmid.abort_after", 32'(abort12), 32'h0);
        run_frame(1'b0, 32'h5A5, 32'hC3C, 1'b0, 1'b0, "post_rst", 32'h5A5, 32'hC3C);
        chk("post_rst.overrun", 32'(ovr12), 32'h0);
        pulse_ack();

`ifdef SPI_SLAVE_PARITY_EN
        run_frame(1'b0, 32'h007, 32'h007, 1'b0, 1'b0, "par_ok", 32'h007, 32'h007);
        pulse_ack();
        run_frame(1'b0, 32'h007, 32'h007, 1'b0, 1'b1, "par_bad", 32'h007, 32'h007);
        pulse_ack();
        chk("par_bad.hold", 32'(perr12), 32'h1);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
